image_resize_avg_simple: RTL and testbench
==========================================

Name: image_resize_avg_simple

Overview:
Box-filter downscaler. On a KEY_2 press it reads a 640x480 8-bit greyscale frame from the frame buffer, one pixel per address, and averages each 16x16 block into one output pixel. The 40x30 result is held in an internal array out[block_y][block_x]. It is then streamed byte-by-byte to a downstream UART transmitter. The block sits between the SDRAM frame-buffer read port and the UART TX.

Parameters:
IMG_W, 640, source width in pixels
IMG_H, 480, source height in pixels
BLK, 16, block edge (power of 2); OUT_W=IMG_W/BLK=40, OUT_H=IMG_H/BLK=30
TX_GAP, 4340, clk cycles between successive uart_trmt pulses (one 10-bit frame at 115200 baud, 50 MHz)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  synchronous active-low reset
KEY_2  in  1  start push-button, active low, asynchronous
Read_DATA2  in  8  pixel data, valid one clk after read_addr_resize is presented
start_resize  out  1  high while the block is reading/averaging
read_addr_resize  out  23  frame-buffer pixel address
done  out  1  high from end of UART stream until next start
uart_tx  out  8  byte to transmit
uart_trmt  out  1  one-cycle transmit strobe for uart_tx

Behaviour:
- Reset (clk edge with rst_n=0): state IDLE; all counters, accumulator, uart_tx, read_addr_resize = 0; start_resize, done, uart_trmt = 0; out[][] contents don't-care.
- KEY_2 passes through a 2-FF synchroniser. A press is a 1→0 transition of the synchronised signal.
- Presses are accepted only in IDLE or DONE; they are ignored while busy.
- Press → state ADDR, done=0, start_resize=1, block_x=block_y=pixel_x=pixel_y=0, acc=0.
- Counters: block_x 0..39, block_y 0..29, pixel_x 0..15, pixel_y 0..15 (all internal, hierarchically visible).
- ADDR (1 cycle):
  - read_addr_resize = (block_y*BLK+pixel_y)*IMG_W + block_x*BLK+pixel_x.
  - Next state SAMPLE.
- SAMPLE (1 cycle): acc (16-bit) += Read_DATA2. Two cycles per pixel, so 512 cycles per block.
- Pixel order within a block is raster: pixel_x increments first, then pixel_y.
- On the last pixel of a block (pixel_x=pixel_y=15), on the same edge:
  - out[block_y][block_x] = (acc + Read_DATA2) >> 8, i.e. the truncated mean;
  - acc = 0, pixel counters wrap to 0;
  - block_x increments, or wraps to 0 and block_y increments.
- Consequently, on the first cycle where block_x=N, block_y=0 and pixel_x=pixel_y=0, out[0][N-1] already holds the final average.
- After block (39,29): start_resize=0, state TX with tx index 0.
- TX: for index 0..1199 in row-major order (out[y][x]):
  - drive uart_tx=out[y][x] and pulse uart_trmt for exactly 1 cycle;
  - wait TX_GAP cycles, then send the next byte;
  - uart_tx holds its value between strobes.
- After byte 1199 plus its gap: state DONE, done=1 (level). done stays high until the next accepted press.
- Reset mid-operation aborts immediately to IDLE with the reset values above. No partial output is resumed.
- Constant input value v gives every out entry exactly v; no rounding error.

Decomposition:
- Package img_resize_pkg holds:
  - IMG_W, IMG_H, BLK and derived OUT_W/OUT_H;
  - ADDR_W=23;
  - the state enum {IDLE, ADDR, SAMPLE, TX, DONE}.
- One sub-module: key_edge_detect (2-FF sync plus falling-edge pulse for KEY_2).
- The averaging FSM, address generator and TX sequencer stay in the top.

Test Plan:
- Reset then idle, KEY_2 held high → start_resize=0, done=0, uart_trmt=0, read_addr_resize=0 for 1000 cycles.
- Read_DATA2 held at 8'd88 (600 truncated); 1-cycle low pulse on KEY_2 → start_resize=1 within 3 cycles. On the first cycle with block_x=1/2/3, block_y=0, pixel 0,0: out[0][0], out[0][1], out[0][2] each = 88. Block 3 is reached in under 2000 cycles.
- Address check → first block addresses 0,1,…,15,640,…,9615; block_x=1 starts at 16; block_y=1 starts at 10240; final address 307199.
- Ramp data, pixel value = pixel_x*16+pixel_y within each block → out entry = 127 (sum 32640>>8). An all-255 block gives 255 with no overflow.
- Full run with TX_GAP=4 → exactly 1200 uart_trmt pulses spaced 5 cycles apart, bytes in row-major order; then done=1. A second KEY_2 press clears done and restarts the run.
- Reset asserted during SAMPLE of block 5 → next cycle state IDLE, all outputs 0. A KEY_2 press pressed mid-run (before the reset) is ignored, with no counter disturbance.

Source files
------------

// File: rtl/img_resize_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | img_resize_pkg : shared geometry, address width and FSM states for    |
// |                  the box-filter downscaler.                            |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package img_resize_pkg;

  localparam int IMG_W      = 640;
  localparam int IMG_H      = 480;
  localparam int BLK        = 16;
  localparam int OUT_W      = IMG_W / BLK;
  localparam int OUT_H      = IMG_H / BLK;
  localparam int ADDR_W     = 23;
  localparam int TX_GAP_DEF = 4340;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    SAMPLE = 3'd2,
    TX     = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/image_resize_avg_simple_key_edge_detect.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | key_edge_detect : two-flop synchroniser for an active-low push-button |
// |                   plus a one-cycle pulse on its falling edge.          |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module key_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Flops reset to the released level so leaving reset never looks like a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= key_n;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign press = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/image_resize_avg_simple.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | image_resize_avg_simple : BLKxBLK box-filter downscaler that reads a  |
// |   frame pixel by pixel, stores block means, then streams them to UART.|
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module image_resize_avg_simple
  import img_resize_pkg::*;
#(
  parameter int SRC_W  = IMG_W,
  parameter int SRC_H  = IMG_H,
  parameter int BLK_SZ = BLK,
  parameter int TX_GAP = TX_GAP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              KEY_2,
  input  logic [7:0]        Read_DATA2,
  output logic              start_resize,
  output logic [ADDR_W-1:0] read_addr_resize,
  output logic              done,
  output logic [7:0]        uart_tx,
  output logic              uart_trmt
);

  localparam int OW      = SRC_W / BLK_SZ;
  localparam int OH      = SRC_H / BLK_SZ;
  localparam int BLK_LOG = $clog2(BLK_SZ);
  localparam int PW      = (BLK_LOG > 0) ? BLK_LOG : 1;
  localparam int BXW     = (OW > 1) ? $clog2(OW) : 1;
  localparam int BYW     = (OH > 1) ? $clog2(OH) : 1;
  localparam int GAP_W   = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;

  state_t          state;
  state_t          state_next;
  logic [BXW-1:0]  block_x;
  logic [BYW-1:0]  block_y;
  logic [PW-1:0]   pixel_x;
  logic [PW-1:0]   pixel_y;
  logic [15:0]     acc;
  logic [7:0]      out [OH][OW];

  logic [BXW-1:0]  r_tx_x;
  logic [BYW-1:0]  r_tx_y;
  logic [GAP_W-1:0] r_gap;
  logic            r_tx_all;

  logic            w_press;
  logic            w_px_last, w_py_last, w_bx_last, w_by_last;
  logic            w_blk_last, w_run_end;
  logic [PW-1:0]   w_px_nxt, w_py_nxt;
  logic [BXW-1:0]  w_bx_nxt;
  logic [BYW-1:0]  w_by_nxt;
  logic [15:0]     w_sum;
  logic [7:0]      w_avg;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic            w_tx_x_last, w_tx_y_last;

  key_edge_detect u_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (KEY_2),
    .press (w_press)
  );

  // Raster walk: pixel_x fastest, then pixel_y, then block_x, then block_y.
  always_comb begin
    w_px_last  = (pixel_x == PW'(BLK_SZ - 1));
    w_py_last  = (pixel_y == PW'(BLK_SZ - 1));
    w_bx_last  = (block_x == BXW'(OW - 1));
    w_by_last  = (block_y == BYW'(OH - 1));
    w_blk_last = w_px_last & w_py_last;
    w_run_end  = w_blk_last & w_bx_last & w_by_last;

    w_px_nxt = w_px_last ? '0 : pixel_x + PW'(1);
    w_py_nxt = pixel_y;
    if (w_px_last)
      w_py_nxt = w_py_last ? '0 : pixel_y + PW'(1);
    w_bx_nxt = block_x;
    if (w_blk_last)
      w_bx_nxt = w_bx_last ? '0 : block_x + BXW'(1);
    w_by_nxt = block_y;
    if (w_blk_last && w_bx_last)
      w_by_nxt = w_by_last ? '0 : block_y + BYW'(1);

    w_addr_nxt = ((ADDR_W'(w_by_nxt) << BLK_LOG) + ADDR_W'(w_py_nxt)) * ADDR_W'(SRC_W)
               + (ADDR_W'(w_bx_nxt) << BLK_LOG) + ADDR_W'(w_px_nxt);

    w_sum = acc + {8'd0, Read_DATA2};
    w_avg = w_sum[2*BLK_LOG +: 8];

    w_tx_x_last = (r_tx_x == BXW'(OW - 1));
    w_tx_y_last = (r_tx_y == BYW'(OH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (w_press) state_next = ADDR;
      ADDR:       state_next = SAMPLE;
      SAMPLE:     state_next = w_run_end ? TX : ADDR;
      TX:         if ((r_gap == '0) && r_tx_all) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      block_x          <= '0;
      block_y          <= '0;
      pixel_x          <= '0;
      pixel_y          <= '0;
      acc              <= '0;
      read_addr_resize <= '0;
      start_resize     <= 1'b0;
      done             <= 1'b0;
      uart_tx          <= '0;
      uart_trmt        <= 1'b0;
      r_tx_x           <= '0;
      r_tx_y           <= '0;
      r_gap            <= '0;
      r_tx_all         <= 1'b0;
    end else begin
      uart_trmt <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (w_press) begin
            done             <= 1'b0;
            start_resize     <= 1'b1;
            block_x          <= '0;
            block_y          <= '0;
            pixel_x          <= '0;
            pixel_y          <= '0;
            acc              <= '0;
            read_addr_resize <= '0;
          end
        end
        SAMPLE: begin
          pixel_x <= w_px_nxt;
          pixel_y <= w_py_nxt;
          block_x <= w_bx_nxt;
          block_y <= w_by_nxt;
          acc     <= w_blk_last ? '0 : w_sum;
          // The last address stays on the bus once the frame is consumed.
          if (w_run_end) begin
            start_resize <= 1'b0;
            r_tx_x       <= '0;
            r_tx_y       <= '0;
            r_gap        <= '0;
            r_tx_all     <= 1'b0;
          end else begin
            read_addr_resize <= w_addr_nxt;
          end
        end
        TX: begin
          if (r_gap != '0) begin
            r_gap <= r_gap - GAP_W'(1);
          end else if (r_tx_all) begin
            done <= 1'b1;
          end else begin
            uart_tx   <= out[r_tx_y][r_tx_x];
            uart_trmt <= 1'b1;
            r_gap     <= GAP_W'(TX_GAP);
            if (w_tx_x_last) begin
              r_tx_x <= '0;
              if (w_tx_y_last)
                r_tx_all <= 1'b1;
              else
                r_tx_y <= r_tx_y + BYW'(1);
            end else begin
              r_tx_x <= r_tx_x + BXW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Result store carries no reset; its contents are only read after a full pass.
  always_ff @(posedge clk) begin
    if ((state == SAMPLE) && w_blk_last)
      out[block_y][block_x] <= w_avg;
  end

endmodule
`default_nettype wire

// File: tb/tb_image_resize_avg_simple.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_image_resize_avg_simple : directed/random bench with a frame model |
// |   and a block-average reference for a reduced 96x48 geometry.         |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_image_resize_avg_simple;
  import img_resize_pkg::*;

  localparam int W   = 96;
  localparam int H   = 48;
  localparam int B   = 16;
  localparam int GAP = 4;
  localparam int OW  = W / B;
  localparam int OH  = H / B;
  localparam int NB  = OW * OH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        KEY_2 = 1'b1;
  logic [7:0]  Read_DATA2 = 8'd0;
  logic        start_resize;
  logic [22:0] read_addr_resize;
  logic        done;
  logic [7:0]  uart_tx;
  logic        uart_trmt;

  image_resize_avg_simple #(
    .SRC_W (W), .SRC_H (H), .BLK_SZ (B), .TX_GAP (GAP)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .KEY_2            (KEY_2),
    .Read_DATA2       (Read_DATA2),
    .start_resize     (start_resize),
    .read_addr_resize (read_addr_resize),
    .done             (done),
    .uart_tx          (uart_tx),
    .uart_trmt        (uart_trmt)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int mode = 0;
  logic [7:0] cval = 8'd0;
  logic [7:0] mem [W*H];
  logic [7:0] exp_out [OH][OW];
  int addr_q[$];
  int exp_addr[$];
  logic [7:0] tx_b[$];
  int tx_t[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pixval(int a);
    int x, y;
    x = a % W;
    y = a / W;
    case (mode)
      0:       return cval;
      1:       return 8'((x % B) * 16 + (y % B));
      default: return ((x / B == 1) && (y / B == 0)) ? 8'hFF : mem[a];
    endcase
  endfunction

  task automatic build_model();
    for (int by = 0; by < OH; by++)
      for (int bx = 0; bx < OW; bx++) begin
        int sum;
        sum = 0;
        for (int y = 0; y < B; y++)
          for (int x = 0; x < B; x++)
            sum += pixval((by * B + y) * W + bx * B + x);
        exp_out[by][bx] = 8'(sum / (B * B));
      end
  endtask

  task automatic build_addr();
    exp_addr.delete();
    for (int by = 0; by < OH; by++)
      for (int bx = 0; bx < OW; bx++)
        for (int py = 0; py < B; py++)
          for (int px = 0; px < B; px++)
            exp_addr.push_back((by * B + py) * W + bx * B + px);
  endtask

  // Frame buffer: data for the address shown in one cycle appears in the next.
  initial begin
    logic [22:0] a;
    forever begin
      @(negedge clk);
      a = read_addr_resize;
      @(posedge clk);
      #1 Read_DATA2 = pixval(int'(a));
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && dut.state == ADDR) addr_q.push_back(int'(read_addr_resize));
    if (uart_trmt) begin
      tx_b.push_back(uart_tx);
      tx_t.push_back(cyc);
    end
  end

  task automatic press();
    @(negedge clk) KEY_2 = 1'b0;
    @(negedge clk) KEY_2 = 1'b1;
  endtask

  task automatic start_run(input string tag);
    addr_q.delete();
    tx_b.delete();
    tx_t.delete();
    build_model();
    press();
    for (int k = 0; k < 3 && !start_resize; k++) @(negedge clk);
    chk({tag, "_start"}, 32'(start_resize), 32'd1);
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
  endtask

  task automatic finish_run(input string tag);
    int bad;
    for (int k = 0; k < 20000 && !done; k++) @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_off"}, 32'(start_resize), 32'd0);
    chk({tag, "_nbytes"}, 32'(tx_b.size()), 32'(NB));
    for (int i = 0; i < tx_b.size() && i < NB; i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(tx_b[i]), 32'(exp_out[i / OW][i % OW]));
    bad = 0;
    for (int i = 1; i < tx_t.size(); i++)
      if (tx_t[i] - tx_t[i-1] != GAP + 1) bad++;
    chk({tag, "_spacing"}, 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < addr_q.size() && i < exp_addr.size(); i++)
      if (addr_q[i] != exp_addr[i]) bad++;
    chk({tag, "_addr_seq"}, 32'(bad), 32'd0);
    chk({tag, "_naddr"}, 32'(addr_q.size()), 32'(exp_addr.size()));
  endtask

  initial begin
    int bad;
    int t0;
    int hit;
    build_addr();

    // Reset and quiet idle
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_busy", 32'(start_resize), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_trmt", 32'(uart_trmt), 32'd0);
    chk("rst_addr", 32'(read_addr_resize), 32'd0);
    rst_n = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (start_resize !== 1'b0 || done !== 1'b0 || uart_trmt !== 1'b0 || read_addr_resize !== 23'd0) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    // Constant 88: block means visible as soon as the next block starts
    mode = 0;
    cval = 8'd88;
    t0 = cyc;
    start_run("const");
    for (int n = 1; n <= 3; n++) begin
      hit = 0;
      for (int k = 0; k < 2000 && !hit; k++) begin
        @(negedge clk);
        if (dut.block_x == 3'(n) && dut.block_y == 2'd0 && dut.pixel_x == 4'd0 && dut.pixel_y == 4'd0) hit = 1;
      end
      chk($sformatf("const_reach%0d", n), 32'(hit), 32'd1);
      chk($sformatf("const_out0_%0d", n - 1), 32'(dut.out[0][n-1]), 32'd88);
    end
    chk("const_blk3_time", 32'(cyc - t0 < 2000), 32'd1);
    finish_run("const");
    chk("addr_first", 32'(addr_q.size() > 0 ? addr_q[0] : -1), 32'd0);
    chk("addr_row1", 32'(addr_q.size() > 16 ? addr_q[16] : -1), 32'(W));
    chk("addr_blk0_end", 32'(addr_q.size() > 255 ? addr_q[255] : -1), 32'(15 * W + 15));
    chk("addr_bx1", 32'(addr_q.size() > 256 ? addr_q[256] : -1), 32'd16);
    chk("addr_by1", 32'(addr_q.size() > OW * 256 ? addr_q[OW * 256] : -1), 32'(16 * W));
    chk("addr_final", 32'(addr_q.size() > 0 ? addr_q[addr_q.size() - 1] : -1), 32'(W * H - 1));
    chk("addr_hold", 32'(read_addr_resize), 32'(W * H - 1));

    // Ramp within each block; second press from DONE restarts
    mode = 1;
    start_run("ramp");
    finish_run("ramp");
    chk("ramp_127", 32'(tx_b.size() > 0 ? tx_b[0] : 8'd0), 32'd127);

    // Random frame with one saturated block
    mode = 2;
    for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);
    start_run("rand");
    finish_run("rand");
    chk("rand_sat255", 32'(tx_b.size() > 1 ? tx_b[1] : 8'd0), 32'd255);

    // Mid-run press ignored, then reset during SAMPLE of block 5
    start_run("abort");
    hit = 0;
    for (int k = 0; k < 4000 && !hit; k++) begin
      @(negedge clk);
      if (dut.block_x == 3'd2) hit = 1;
    end
    press();
    hit = 0;
    for (int k = 0; k < 4000 && !hit; k++) begin
      @(negedge clk);
      if (dut.block_x == 3'd5 && dut.state == SAMPLE) hit = 1;
    end
    chk("abort_reach5", 32'(hit), 32'd1);
    bad = 0;
    for (int i = 0; i < addr_q.size() && i < exp_addr.size(); i++)
      if (addr_q[i] != exp_addr[i]) bad++;
    chk("abort_addr_prefix", 32'(bad), 32'd0);
    chk("abort_naddr", 32'(addr_q.size() > 5 * 256), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_state", 32'(dut.state), 32'(IDLE));
    chk("abort_busy", 32'(start_resize), 32'd0);
    chk("abort_addr", 32'(read_addr_resize), 32'd0);
    chk("abort_tx", 32'(uart_tx), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_cnt", 32'({dut.block_x, dut.block_y, dut.pixel_x, dut.pixel_y}), 32'd0);
    chk("abort_acc", 32'(dut.acc), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_state", 32'(dut.state), 32'(IDLE));
    chk("post_busy", 32'(start_resize), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
